call_scheduler: RTL
===================

Name: call_scheduler

Overview:
Dispatch scheduler for the single elevator car. Latches hall up/down calls and in-car floor buttons into pending registers, and runs a SCAN (collective) policy to choose travel direction. Issues one-floor move requests and door-open requests to the motion/door controller. Sits between the input processor (request pulses) and the status-transition/motion block (cur_floor, arrived, door_done). Drives the display's pending-call LEDs.

Parameters:
FLOORS, 8, number of floors; bit i of every vector = floor i
FLOOR_W, 3, width of floor index (clog2(FLOORS))
PARK_CYCLES, 255, idle cycles before auto-park (PARK_EN only); 8-bit counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
up_req  in  FLOORS  1-cycle pulses, hall up call per floor
down_req  in  FLOORS  1-cycle pulses, hall down call per floor
car_req  in  FLOORS  1-cycle pulses, in-car floor button per floor
clear_all  in  1  synchronous flush of all pending calls
cur_floor  in  FLOOR_W  current car floor from motion block
arrived  in  1  pulse: car has settled at cur_floor after a move
door_done  in  1  pulse: door open/close cycle finished
up_pend  out  FLOORS  registered pending up calls
down_pend  out  FLOORS  registered pending down calls
car_pend  out  FLOORS  registered pending car calls
dir  out  2  00 idle, 01 up, 10 down (11 never driven)
move_req  out  1  level: move one floor in dir; high in UP/DOWN until arrived
open_req  out  1  1-cycle pulse: open door at cur_floor
target  out  FLOOR_W  next floor to serve
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async): all pend regs 0, state IDLE, dir 00, move_req 0, open_req 0, busy 0. Reset mid-move or mid-door drops all calls; no open_req is generated.
- Pending set: pend |= req each cycle. up_req[FLOORS-1] and down_req[0] are masked (never set). clear_all clears all three vectors. clear_all wins over same-cycle requests.
- Definitions, from registered pend: here = any pend bit at cur_floor. above = any pend at floor > cur_floor. below = any pend at floor < cur_floor.
- FSM states: IDLE, UP, DOWN, STOP. All transitions are registered, with 1-cycle decision latency.
- IDLE:
  - here -> STOP.
  - else above -> UP.
  - else below -> DOWN.
  - Priority: here > above > below.
- UP: dir=01, move_req=1. On arrived, stop at cur_floor if any of:
  - car_pend[cur] or up_pend[cur];
  - down_pend[cur] and no pend above;
  - no pend above at all (safety).
  - Stop -> STOP. Otherwise remain UP.
- DOWN: mirror of UP (down_pend/car_pend; up_pend[cur] only if nothing below).
- STOP: move_req=0.
  - open_req pulses on the entry cycle only.
  - On entry, clear car_pend[cur].
  - Clear up_pend[cur] if dir is 01 or 00. Clear down_pend[cur] if dir is 10 or 00.
  - While in STOP, new requests for cur_floor in the served direction and car_req[cur] are ignored.
  - On door_done, keep direction if calls remain that way: dir 01 and above -> UP; dir 10 and below -> DOWN.
  - Otherwise reverse: remaining opposite-side calls -> other direction.
  - A call still pending at cur (opposite hall call) -> STOP again with the new dir, a fresh open_req, and that call cleared.
  - Nothing pending -> IDLE, dir 00.
- target:
  - UP: lowest pending floor > cur_floor.
  - DOWN: highest pending floor < cur_floor.
  - IDLE/STOP: cur_floor.
- Boundaries: cur_floor at 0 never enters DOWN; at FLOORS-1 never enters UP. arrived/door_done in a state that does not expect them are ignored.

Optional Feature:
CALL_PARK_EN
- Defined: in IDLE with no pending calls, an 8-bit counter increments per cycle. At PARK_CYCLES with cur_floor != 0, car_pend[0] is set, which leads to travel to floor 0. The counter resets on any request, on clear_all, or on leaving IDLE.
- Undefined: the counter is absent and the car stays where it is.

Test Plan:
1. Reset release, cur_floor=0, car_req=8'h20 pulse -> car_pend=8'h20; next cycle state UP, dir=01, move_req=1, target=5; arrived at cur 1..4 gives no stop; arrived at 5 -> open_req 1 cycle, car_pend=0; door_done -> IDLE, dir=00, busy=0.
2. At floor 2 going UP to 6, down_req[4] and up_req[4] pulses -> at floor 4 stop for up call only, up_pend[4] cleared, down_pend[4] stays 1; continue to 6; then DOWN, stop at 4, down_pend cleared.
3. Idle at floor 3, up_req[3] pulse -> STOP, open_req pulse, up_pend=0, no move_req; down_req[0] and up_req[7] pulses -> pend vectors unchanged.
4. UP in progress, rst pulled low between arrivals -> outputs zero immediately (async); after release, IDLE with no further move_req.
5. Idle at 4, car_req=8'h81 same cycle -> above wins: UP to 7, then DOWN to 0; clear_all and car_req[2] in same cycle -> car_pend=0.
6. CALL_PARK_EN, PARK_CYCLES=4, idle at floor 3 -> car_pend[0] set after 4 cycles, DOWN to 0; idle at 0 -> no park.

Source files
------------

// File: rtl/call_scheduler.sv
// call_scheduler: dispatch scheduler for a single elevator car.
// Latches hall up/down calls and car buttons into pending vectors and runs a
// SCAN (collective) policy to pick the travel direction. It issues one-floor
// move requests and door-open pulses to the motion/door controller.
// Optional feature macro: CALL_PARK_EN (auto-park to floor 0 after an idle
// period). With the macro undefined the car simply stays where it is.
//
// Handshake: there is no valid/ready pairing on this block. up_req, down_req,
// car_req, clear_all, arrived and door_done are single-cycle pulses sampled on
// the rising edge. move_req is a level held while the car should travel one
// floor in dir, and it drops on the edge that accepts the stopping arrived.
// open_req is a one-cycle pulse on the first cycle of every stop.
module call_scheduler #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = 3,
  parameter int PARK_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  up_req,
  input  logic [FLOORS-1:0]  down_req,
  input  logic [FLOORS-1:0]  car_req,
  input  logic               clear_all,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               arrived,
  input  logic               door_done,
  output logic [FLOORS-1:0]  up_pend,
  output logic [FLOORS-1:0]  down_pend,
  output logic [FLOORS-1:0]  car_pend,
  output logic [1:0]         dir,
  output logic               move_req,
  output logic               open_req,
  output logic [FLOOR_W-1:0] target,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_STOP = 2'd3
  } state_t;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  // There is no up call at the top floor and no down call at the bottom floor.
  localparam logic [FLOORS-1:0] UP_MASK = ~(FLOORS'(1) << (FLOORS - 1));
  localparam logic [FLOORS-1:0] DN_MASK = ~FLOORS'(1);

  // The idle counter is 8 bits wide, so the park delay must fit in it.
  if (PARK_CYCLES < 1 || PARK_CYCLES > 255) begin : g_park_cycles_range
    $error("call_scheduler: PARK_CYCLES must be in 1..255");
  end

  state_t             state;
  state_t             nxt_state;
  logic [1:0]         nxt_dir;
  logic               enter_stop;

  logic [FLOORS-1:0]  all_pend;
  logic [FLOORS-1:0]  cur_oh;
  logic [FLOORS-1:0]  above_mask;
  logic [FLOORS-1:0]  below_mask;
  logic               here;
  logic               above;
  logic               below;
  logic               up_stop;
  logic               dn_stop;
  logic [FLOOR_W-1:0] up_tgt;
  logic [FLOOR_W-1:0] dn_tgt;

  logic [FLOORS-1:0]  ign_up;
  logic [FLOORS-1:0]  ign_dn;
  logic [FLOORS-1:0]  ign_car;
  logic [FLOORS-1:0]  clr_up;
  logic [FLOORS-1:0]  clr_dn;
  logic [FLOORS-1:0]  clr_car;
  logic [FLOORS-1:0]  park_set;

  assign all_pend  = up_pend | down_pend | car_pend;
  assign cur_oh    = FLOORS'(1) << cur_floor;
  assign here      = |(all_pend & cur_oh);
  assign above     = |(all_pend & above_mask);
  assign below     = |(all_pend & below_mask);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Floor masks strictly above and strictly below the car.
  always_comb begin
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      above_mask[i] = (i > int'(cur_floor));
      below_mask[i] = (i < int'(cur_floor));
    end
  end

  // Nearest pending floor above (lowest) and below (highest) the car.
  always_comb begin
    up_tgt = cur_floor;
    dn_tgt = cur_floor;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (above_mask[i] && all_pend[i]) up_tgt = FLOOR_W'(i);
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (below_mask[i] && all_pend[i]) dn_tgt = FLOOR_W'(i);
    end
  end

  // Stop tests at the floor just reached; running out of calls ahead always
  // stops the car so it never travels past the last call.
  always_comb begin
    up_stop = car_pend[cur_floor] | up_pend[cur_floor]
            | (down_pend[cur_floor] & ~above) | ~above;
    dn_stop = car_pend[cur_floor] | down_pend[cur_floor]
            | (up_pend[cur_floor] & ~below) | ~below;
  end

  // Target floor presented to the display and the motion block.
  always_comb begin
    case (state)
      S_UP:    target = up_tgt;
      S_DOWN:  target = dn_tgt;
      default: target = cur_floor;
    endcase
  end

  // SCAN next-state decision from the registered pending vectors.
  always_comb begin
    nxt_state  = state;
    nxt_dir    = dir;
    enter_stop = 1'b0;
    case (state)
      S_IDLE: begin
        if (here) begin
          nxt_state  = S_STOP;
          nxt_dir    = DIR_IDLE;
          enter_stop = 1'b1;
        end else if (above) begin
          nxt_state = S_UP;
          nxt_dir   = DIR_UP;
        end else if (below) begin
          nxt_state = S_DOWN;
          nxt_dir   = DIR_DN;
        end
      end
      S_UP: begin
        if (arrived && up_stop) begin
          nxt_state  = S_STOP;
          enter_stop = 1'b1;
        end
      end
      S_DOWN: begin
        if (arrived && dn_stop) begin
          nxt_state  = S_STOP;
          enter_stop = 1'b1;
        end
      end
      S_STOP: begin
        if (door_done) begin
          if (dir == DIR_UP && above) begin
            nxt_state = S_UP;
          end else if (dir == DIR_DN && below) begin
            nxt_state = S_DOWN;
          end else if (dir != DIR_IDLE && here) begin
            // Opposite hall call waiting at this floor: reopen for it.
            nxt_state  = S_STOP;
            nxt_dir    = (dir == DIR_UP) ? DIR_DN : DIR_UP;
            enter_stop = 1'b1;
          end else if (above) begin
            nxt_state = S_UP;
            nxt_dir   = DIR_UP;
          end else if (below) begin
            nxt_state = S_DOWN;
            nxt_dir   = DIR_DN;
          end else begin
            nxt_state = S_IDLE;
            nxt_dir   = DIR_IDLE;
          end
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_dir   = DIR_IDLE;
      end
    endcase
  end

  // FSM state and registered motion/door outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      dir      <= DIR_IDLE;
      move_req <= 1'b0;
      open_req <= 1'b0;
    end else begin
      state    <= nxt_state;
      dir      <= nxt_dir;
      move_req <= (nxt_state == S_UP) || (nxt_state == S_DOWN);
      open_req <= enter_stop;
    end
  end

  // Calls being served at the current floor: ignore new ones while stopped
  // and clear the latched ones on the stop entry edge (using the stop's dir).
  always_comb begin
    ign_car = '0;
    ign_up  = '0;
    ign_dn  = '0;
    clr_car = '0;
    clr_up  = '0;
    clr_dn  = '0;
    if (state == S_STOP) begin
      ign_car = cur_oh;
      if (dir != DIR_DN) ign_up = cur_oh;
      if (dir != DIR_UP) ign_dn = cur_oh;
    end
    if (enter_stop) begin
      clr_car = cur_oh;
      if (nxt_dir != DIR_DN) clr_up = cur_oh;
      if (nxt_dir != DIR_UP) clr_dn = cur_oh;
    end
  end

`ifdef CALL_PARK_EN
  logic [7:0] park_cnt;
  logic       idle_empty;
  logic       any_req;
  logic       park_fire;

  assign idle_empty = (state == S_IDLE) && (all_pend == '0);
  assign any_req    = |{up_req, down_req, car_req};
  assign park_fire  = idle_empty && !any_req && !clear_all
                    && (park_cnt == 8'(PARK_CYCLES)) && (cur_floor != '0);
  assign park_set   = park_fire ? FLOORS'(1) : '0;

  // Idle counter: runs only while idle with nothing pending, saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      park_cnt <= '0;
    end else if (!idle_empty || any_req || clear_all) begin
      park_cnt <= '0;
    end else if (park_cnt != 8'(PARK_CYCLES)) begin
      park_cnt <= park_cnt + 8'd1;
    end
  end
`else
  assign park_set = '0;
`endif

  // Pending call registers; clear_all overrides everything in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_pend   <= '0;
      down_pend <= '0;
      car_pend  <= '0;
    end else if (clear_all) begin
      up_pend   <= '0;
      down_pend <= '0;
      car_pend  <= '0;
    end else begin
      up_pend   <= (up_pend   | (up_req   & UP_MASK & ~ign_up)) & ~clr_up;
      down_pend <= (down_pend | (down_req & DN_MASK & ~ign_dn)) & ~clr_dn;
      car_pend  <= (car_pend  | (car_req & ~ign_car) | park_set) & ~clr_car;
    end
  end

endmodule
